// File: rtl/gan_output_collector.sv
// -----------------------------------------------------------------------------
// gan_output_collector
//   Captures the nine generator pixels and the discriminator score produced by
//   the GAN top level, then streams them out as ten words over a valid/ready
//   handshake: pixels 1x1..3x3 at indices 0..8, score at index 9 (out_last).
//
//   Optional watchdog: define GAN_COLLECTOR_TIMEOUT_EN to build in a counter
//   that aborts a WAIT_DISC phase lasting TIMEOUT cycles and raises a sticky
//   timeout_err. Without the macro WAIT_DISC waits indefinitely and
//   timeout_err is tied 0.
//
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   gen_finish          generator result valid (level, rising edge used)
//   disc_finish         discriminator result valid (level, rising edge used)
//   pixel_1x1..3x3      generator pixels, signed WIDTH
//   out_discriminator   discriminator score, signed WIDTH
//   out_data/out_valid/out_ready/out_last/out_index   output word stream
//   busy                high while waiting for the score or streaming
//   timeout_err         sticky watchdog flag
// -----------------------------------------------------------------------------
module gan_output_collector #(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 31
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    gen_finish,
   input  logic                    disc_finish,
   input  logic signed [WIDTH-1:0] pixel_1x1,
   input  logic signed [WIDTH-1:0] pixel_1x2,
   input  logic signed [WIDTH-1:0] pixel_1x3,
   input  logic signed [WIDTH-1:0] pixel_2x1,
   input  logic signed [WIDTH-1:0] pixel_2x2,
   input  logic signed [WIDTH-1:0] pixel_2x3,
   input  logic signed [WIDTH-1:0] pixel_3x1,
   input  logic signed [WIDTH-1:0] pixel_3x2,
   input  logic signed [WIDTH-1:0] pixel_3x3,
   input  logic signed [WIDTH-1:0] out_discriminator,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    out_last,
   output logic [3:0]              out_index,
   output logic                    busy,
   output logic                    timeout_err
);

   typedef enum logic [1:0] {IDLE, WAIT_DISC, STREAM, DONE} state_t;

   state_t                  state;
   logic                    gen_prev, disc_prev;
   logic                    gen_rise, disc_rise;
   logic signed [WIDTH-1:0] pix_buf [0:8];
   logic signed [WIDTH-1:0] disc_buf;
   logic [3:0]              idx;
   logic                    accept;

   assign gen_rise  = gen_finish  & ~gen_prev;
   assign disc_rise = disc_finish & ~disc_prev;
   assign accept    = out_valid & out_ready;

   // Output word is selected straight from the capture buffers, so it holds
   // automatically while the index is stalled by backpressure.
   assign out_data  = (idx < 4'd9) ? pix_buf[idx] : disc_buf;
   assign out_index = idx;
   assign out_last  = out_valid & (idx == 4'd9);

`ifdef GAN_COLLECTOR_TIMEOUT_EN
   localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);
   logic [4:0] wd_cnt;
   logic       timeout_q;
   assign timeout_err = timeout_q;
`else
   // TIMEOUT has no effect when the watchdog is not built in.
   assign timeout_err = 1'b0 & (TIMEOUT > 0);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         gen_prev  <= 1'b0;
         disc_prev <= 1'b0;
         for (int i = 0; i < 9; i++) pix_buf[i] <= '0;
         disc_buf  <= '0;
         idx       <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
`ifdef GAN_COLLECTOR_TIMEOUT_EN
         wd_cnt    <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         gen_prev  <= gen_finish;
         disc_prev <= disc_finish;
         case (state)
            IDLE, DONE: begin
               if (gen_rise) begin
                  pix_buf[0] <= pixel_1x1;
                  pix_buf[1] <= pixel_1x2;
                  pix_buf[2] <= pixel_1x3;
                  pix_buf[3] <= pixel_2x1;
                  pix_buf[4] <= pixel_2x2;
                  pix_buf[5] <= pixel_2x3;
                  pix_buf[6] <= pixel_3x1;
                  pix_buf[7] <= pixel_3x2;
                  pix_buf[8] <= pixel_3x3;
                  busy       <= 1'b1;
                  // Coincident score edge: skip WAIT_DISC entirely.
                  if (disc_rise) begin
                     disc_buf  <= out_discriminator;
                     idx       <= '0;
                     out_valid <= 1'b1;
                     state     <= STREAM;
                  end else begin
                     state     <= WAIT_DISC;
`ifdef GAN_COLLECTOR_TIMEOUT_EN
                     wd_cnt    <= '0;
`endif
                  end
               end
            end
            WAIT_DISC: begin
               if (disc_rise) begin
                  disc_buf  <= out_discriminator;
                  idx       <= '0;
                  out_valid <= 1'b1;
                  state     <= STREAM;
`ifdef GAN_COLLECTOR_TIMEOUT_EN
               end else if (wd_cnt == TO_LAST) begin
                  // Counter would reach TIMEOUT on this edge: abandon the run.
                  timeout_q <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end else begin
                  wd_cnt    <= wd_cnt + 5'd1;
`endif
               end
            end
            STREAM: begin
               if (accept) begin
                  if (idx == 4'd9) begin
                     idx       <= '0;
                     out_valid <= 1'b0;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end else begin
                     idx <= idx + 4'd1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gan_output_collector.sv
// -----------------------------------------------------------------------------
// tb_gan_output_collector
//   Self-checking bench for gan_output_collector. A table of directed runs and
//   a set of randomized runs are each checked against a transaction-level
//   model: a run is expected to yield exactly the nine captured pixels in
//   row-major order followed by the captured score, one word per accepted
//   handshake, independent of stall pattern or spurious finish edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gan_output_collector;

   localparam int W = 32;
   typedef logic signed [W-1:0] word_t;
   typedef word_t words_t [10];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        gen_finish = 1'b0;
   logic        disc_finish = 1'b0;
   word_t       pix [9];
   word_t       disc_in = '0;
   logic [W-1:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic [3:0]  out_index;
   logic        busy;
   logic        timeout_err;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   gan_output_collector #(.WIDTH(W), .TIMEOUT(31)) dut (
      .clk(clk), .rst(rst),
      .gen_finish(gen_finish), .disc_finish(disc_finish),
      .pixel_1x1(pix[0]), .pixel_1x2(pix[1]), .pixel_1x3(pix[2]),
      .pixel_2x1(pix[3]), .pixel_2x2(pix[4]), .pixel_2x3(pix[5]),
      .pixel_3x1(pix[6]), .pixel_3x2(pix[7]), .pixel_3x3(pix[8]),
      .out_discriminator(disc_in),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .out_index(out_index),
      .busy(busy), .timeout_err(timeout_err)
   );

   task automatic check(input bit ok, input string name, input longint act, input longint exp);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic scramble_inputs();
      for (int i = 0; i < 9; i++) pix[i] = word_t'($urandom);
      disc_in = word_t'($urandom);
   endtask

   // Present a run's data, raise the finish edges and leave the bench at the
   // negedge after the score capture edge (first cycle of the stream).
   task automatic start_run(input words_t w, input int gap, input bit spur_disc);
      gen_finish = 1'b0; disc_finish = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      if (spur_disc) begin
         disc_in = word_t'($urandom);
         disc_finish = 1'b1;
         @(negedge clk);
         disc_finish = 1'b0;
         @(negedge clk);
         check(busy === 1'b0, "spur_disc_busy", busy, 0);
         check(out_valid === 1'b0, "spur_disc_valid", out_valid, 0);
      end
      for (int i = 0; i < 9; i++) pix[i] = w[i];
      gen_finish = 1'b1;
      if (gap == 0) begin
         disc_in = w[9];
         disc_finish = 1'b1;
      end
      @(negedge clk);
      gen_finish = 1'b0;
      disc_finish = 1'b0;
      scramble_inputs();
      check(busy === 1'b1, "busy_after_gen", busy, 1);
      if (gap != 0) begin
         check(out_valid === 1'b0, "no_valid_wait_disc", out_valid, 0);
         repeat (gap - 1) @(negedge clk);
         disc_in = w[9];
         disc_finish = 1'b1;
         @(negedge clk);
         disc_finish = 1'b0;
         scramble_inputs();
      end
      check(out_valid === 1'b1, "valid_first_cycle", out_valid, 1);
   endtask

   // ready_pct < 0 selects the fixed 1,0,0 ready pattern. stop_after >= 0
   // returns while word stop_after is presented (used for reset aborts).
   task automatic stream_check(input words_t w, input int ready_pct, input bit spur_gen,
                               input int stop_after);
      int  cnt = 0;
      int  cyc = 0;
      bit  spur_done = 0;
      while (cnt < 10 && cyc < 300) begin
         if (cnt == stop_after) return;
         check(out_valid === 1'b1, "valid_held", out_valid, 1);
         check(out_data === w[cnt], "data", $signed(out_data), w[cnt]);
         check(out_index === 4'(cnt), "index", out_index, cnt);
         check(out_last === (cnt == 9), "last", out_last, (cnt == 9));
         gen_finish = 1'b0;
         if (spur_gen && cnt == 3 && !spur_done) begin
            scramble_inputs();
            gen_finish = 1'b1;
            spur_done = 1;
         end
         if (ready_pct < 0) out_ready = (cyc % 3 == 0);
         else out_ready = ($urandom_range(0, 99) < ready_pct);
         if (out_ready) cnt++;
         @(negedge clk);
         cyc++;
      end
      gen_finish = 1'b0;
      out_ready = 1'b0;
      check(cnt == 10, "stream_budget", cnt, 10);
      check(out_valid === 1'b0, "valid_drop", out_valid, 0);
      check(out_index === 4'd0, "index_return", out_index, 0);
      check(out_last === 1'b0, "last_drop", out_last, 0);
      check(busy === 1'b0, "busy_drop", busy, 0);
   endtask

   typedef struct {
      int base;
      int score;
      int gap;
      int ready_pct;
      bit spur_disc;
      bit spur_gen;
      int exp_last;
   } vec_t;

   vec_t vecs [5];

   function automatic words_t make_words(input int base, input int score);
      words_t w;
      for (int k = 0; k < 9; k++) w[k] = word_t'(base + k);
      w[9] = word_t'(score);
      return w;
   endfunction

   initial begin
      words_t w;

      vecs[0] = '{1, -5, 10, 100, 0, 0, -5};
      vecs[1] = '{100, -1, 3, -1, 0, 0, -1};
      vecs[2] = '{-50, 32'h7FFFFFFF, 0, 100, 0, 0, 32'h7FFFFFFF};
      vecs[3] = '{int'(32'h80000000), 12345, 2, 60, 1, 1, 12345};
      vecs[4] = '{7, 0, 1, 50, 1, 0, 0};

      for (int i = 0; i < 9; i++) pix[i] = '0;
      #1;
      check(out_valid === 1'b0, "rst_valid", out_valid, 0);
      check(out_data === '0, "rst_data", out_data, 0);
      check(out_index === 4'd0, "rst_index", out_index, 0);
      check(out_last === 1'b0, "rst_last", out_last, 0);
      check(busy === 1'b0, "rst_busy", busy, 0);
      check(timeout_err === 1'b0, "rst_timeout", timeout_err, 0);
      @(negedge clk);
      rst = 1'b1;

      // Directed table.
      for (int v = 0; v < 5; v++) begin
         w = make_words(vecs[v].base, vecs[v].score);
         check(w[9] === word_t'(vecs[v].exp_last), "table_last_word", w[9], vecs[v].exp_last);
         start_run(w, vecs[v].gap, vecs[v].spur_disc);
         stream_check(w, vecs[v].ready_pct, vecs[v].spur_gen, -1);
      end

      // Reset after four accepted words aborts the stream immediately.
      w = make_words(200, -77);
      start_run(w, 2, 0);
      stream_check(w, 100, 0, 4);
      rst = 1'b0;
      out_ready = 1'b1;
      #1;
      check(out_valid === 1'b0, "abort_valid", out_valid, 0);
      check(out_index === 4'd0, "abort_index", out_index, 0);
      check(out_data === '0, "abort_data", out_data, 0);
      check(busy === 1'b0, "abort_busy", busy, 0);
      // gen_finish already high at release must count as a rise.
      w = make_words(-1000, 99);
      for (int i = 0; i < 9; i++) pix[i] = w[i];
      gen_finish = 1'b1;
      @(negedge clk);
      check(out_valid === 1'b0, "abort_no_words", out_valid, 0);
      rst = 1'b1;
      out_ready = 1'b0;
      @(negedge clk);
      check(busy === 1'b1, "gen_high_at_release", busy, 1);
      gen_finish = 1'b0;
      scramble_inputs();
      disc_in = w[9];
      disc_finish = 1'b1;
      @(negedge clk);
      disc_finish = 1'b0;
      scramble_inputs();
      check(out_valid === 1'b1, "post_reset_valid", out_valid, 1);
      stream_check(w, 70, 0, -1);

      // Randomized runs against the transaction model.
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 10; k++) w[k] = word_t'($urandom);
         start_run(w, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
         stream_check(w, $urandom_range(30, 100), 1'($urandom_range(0, 1)), -1);
      end

`ifdef GAN_COLLECTOR_TIMEOUT_EN
      begin
         int  busy_cycles = 0;
         bit  saw_valid = 0;
         @(negedge clk);
         gen_finish = 1'b1;
         @(negedge clk);
         gen_finish = 1'b0;
         while (busy && busy_cycles < 100) begin
            if (out_valid) saw_valid = 1;
            busy_cycles++;
            @(negedge clk);
         end
         check(busy_cycles == 31, "timeout_cycles", busy_cycles, 31);
         check(timeout_err === 1'b1, "timeout_flag", timeout_err, 1);
         check(saw_valid == 0 && out_valid === 1'b0, "timeout_no_stream", saw_valid, 0);
         repeat (3) @(negedge clk);
         check(timeout_err === 1'b1, "timeout_sticky", timeout_err, 1);
      end
`else
      w = make_words(55, -55);
      @(negedge clk);
      for (int i = 0; i < 9; i++) pix[i] = w[i];
      gen_finish = 1'b1;
      @(negedge clk);
      gen_finish = 1'b0;
      scramble_inputs();
      repeat (40) @(negedge clk);
      check(busy === 1'b1, "wait_forever_busy", busy, 1);
      check(out_valid === 1'b0, "wait_forever_valid", out_valid, 0);
      check(timeout_err === 1'b0, "no_timeout_flag", timeout_err, 0);
      disc_in = w[9];
      disc_finish = 1'b1;
      @(negedge clk);
      disc_finish = 1'b0;
      scramble_inputs();
      stream_check(w, 100, 0, -1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gan_output_collector.md
GAN_OUTPUT_COLLECTOR -- requirements
Module: gan_output_collector

Interface
REQ-001 Parameters SHALL be WIDTH, default 32, signed word width; TIMEOUT, default 31, watchdog limit in cycles.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; asynchronous, active-low.
REQ-004 gen_finish  input  1  generator-result-valid level from the GAN top level.
REQ-005 disc_finish  input  1  discriminator-result-valid level from the GAN top level.
REQ-006 pixel_1x1 .. pixel_3x3  input  WIDTH each (9 ports, signed)  generator pixels.
REQ-007 out_discriminator  input  WIDTH (signed)  discriminator score.
REQ-008 out_data  output  WIDTH  streamed word.
REQ-009 out_valid  output  1  out_data valid.
REQ-010 out_ready  input  1  downstream accepts a word when out_valid and out_ready are both high.
REQ-011 out_last  output  1  high with the 10th word, the discriminator score.
REQ-012 out_index  output  4  index of the current word, 0..9.
REQ-013 busy  output  1  high in WAIT_DISC and STREAM.
REQ-014 timeout_err  output  1  sticky watchdog flag; tied 0 when the feature is compiled out.

Function
REQ-015 The block SHALL detect rising edges of gen_finish and disc_finish using one registered previous-sample flop each (rise = input & ~prev).
REQ-016 The FSM SHALL have exactly the states IDLE, WAIT_DISC, STREAM, DONE.
- IDLE --gen rise--> WAIT_DISC
- WAIT_DISC --disc rise--> STREAM
- STREAM --last word accepted--> DONE
- DONE --gen rise--> WAIT_DISC
REQ-017 On a gen_finish rise in IDLE or DONE, the block SHALL capture all 9 pixels into a 9xWIDTH buffer on that clock edge.
REQ-018 On a disc_finish rise in WAIT_DISC, the block SHALL capture out_discriminator on that clock edge.
REQ-019 A gen and disc rise in the same cycle in IDLE/DONE SHALL capture both and go directly to STREAM.
REQ-020 out_valid SHALL assert in the first cycle after entering STREAM, i.e. one cycle after the disc capture edge.
REQ-021 Stream order SHALL be row-major 1x1,1x2,1x3,2x1,...,3x3 at indices 0..8, then the discriminator score at index 9.
REQ-022 out_index SHALL increment only on an accepted word and SHALL never exceed 9.
REQ-023 When out_valid is high and out_ready is low, out_data, out_index and out_last SHALL hold stable.
REQ-024 When the index-9 word is accepted, out_valid SHALL deassert on the next cycle and out_index SHALL return to 0.
REQ-025 A disc_finish rise outside WAIT_DISC SHALL be ignored.
REQ-026 A gen_finish rise in WAIT_DISC or STREAM SHALL be ignored, and the captured data SHALL not be overwritten.
REQ-027 The block SHALL perform no arithmetic on data; words pass bit-exact.

Reset
REQ-028 When rst is low, the block SHALL asynchronously set:
- state to IDLE
- both edge-detect flops, the capture buffers, out_data, out_index, the watchdog counter and timeout_err to 0
- out_valid, out_last and busy to 0
REQ-029 Reset asserted mid-STREAM SHALL abort the stream with no further words.
REQ-030 After reset release, a finish input already high SHALL count as a rise on the first clock edge.

Configuration
REQ-031 The watchdog SHALL be compiled in if and only if the macro GAN_COLLECTOR_TIMEOUT_EN is defined.
REQ-032 With GAN_COLLECTOR_TIMEOUT_EN defined:
- a 5-bit counter SHALL clear on WAIT_DISC entry and increment each cycle in WAIT_DISC
- when the counter reaches TIMEOUT, the block SHALL set timeout_err and return to IDLE without streaming
- timeout_err SHALL clear only on reset
REQ-033 Without GAN_COLLECTOR_TIMEOUT_EN, the counter SHALL not exist, timeout_err SHALL be constant 0, and WAIT_DISC SHALL wait indefinitely.

Verification
REQ-034 Basic stream: pixels 1..9, score -5, gen rise at cycle 10, disc rise at cycle 20, out_ready=1 -> words 1..9, -5 on cycles 21..30; out_last only with -5.
REQ-035 Backpressure: out_ready toggled 1,0,0,1,... -> no word lost or duplicated; data stable while stalled; 10 accepted words in order.
REQ-036 Same-cycle rises in IDLE -> STREAM entered directly; all 10 words correct.
REQ-037 Reset pulse after 4 accepted words -> outputs 0 at once; no further words; a new run then streams correctly from index 0.
REQ-038 Spurious edges: disc rise before gen rise, and gen re-rise during STREAM -> both ignored; original data streamed.
REQ-039 With GAN_COLLECTOR_TIMEOUT_EN and TIMEOUT=31: gen rise, no disc rise -> timeout_err=1 after 31 cycles, state IDLE, out_valid never 1.
